// File: rtl/dpu_pkg.sv
// Shared constants and types for the dot-product unit controller.
// Register addresses, STATUS/CTRL bit positions and the sequencer state type.
package dpu_pkg;

   localparam logic [31:0] DPU_CTRL = 32'd0;
   localparam logic [31:0] DPU_A    = 32'd4;
   localparam logic [31:0] DPU_B    = 32'd8;

   localparam int unsigned STAT_BUSY   = 0;
   localparam int unsigned STAT_DONE   = 1;
   localparam int unsigned STAT_OVF    = 2;
   localparam int unsigned STAT_WA_LSB = 8;
   localparam int unsigned STAT_WB_LSB = 12;

   localparam int unsigned CTRL_START = 0;
   localparam int unsigned CTRL_CLEAR = 1;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } dpu_state_t;

endpackage

// File: rtl/dpu_if.sv
// MMIO request/acknowledge port between the CPU splitter (master) and the DPU (slave).
interface dpu_if;

   logic        dp_req;
   logic        dp_lw;
   logic [31:0] dp_addr;
   logic [31:0] dp_write_data;
   logic        dp_ack;
   logic [31:0] dp_read_data;

   modport master (
      output dp_req, dp_lw, dp_addr, dp_write_data,
      input  dp_ack, dp_read_data
   );

   modport slave (
      input  dp_req, dp_lw, dp_addr, dp_write_data,
      output dp_ack, dp_read_data
   );

endinterface

// File: rtl/dpu_mac.sv
// Registered multiply-accumulate; the product and the sum both wrap modulo 2^32.
module dpu_mac (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        en,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] acc
);

   logic [31:0] prod;

   assign prod = a * b;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
      end else if (clr) begin
         acc <= '0;
      end else if (en) begin
         acc <= acc + prod;
      end
   end

endmodule

// File: rtl/dpu_ctrl.sv
// Memory-mapped front end and sequencer for the dot-product unit: buffers
// operand vectors A/B and steps one multiply-accumulate per cycle over them.
module dpu_ctrl
   import dpu_pkg::*;
#(
   parameter int unsigned DEPTH = 8,
   parameter int unsigned PW    = $clog2(DEPTH + 1)
) (
   input  logic clk,
   input  logic rst,
   dpu_if.slave dp
);

   localparam logic [PW-1:0] FULL = PW'(DEPTH);
   localparam logic [PW-1:0] ONE  = PW'(1);

   dpu_state_t    state_q, state_d;
   logic [PW-1:0] wa_q, wb_q, idx_q, n_q, n_last_q;
   logic [PW-1:0] n_next, n_done;
   logic          ovf_q;
   logic          ack_q;
   logic [31:0]   rdata_q, rd_mux, status;
   logic [31:0]   buf_a [DEPTH];
   logic [31:0]   buf_b [DEPTH];
   logic [31:0]   a_op, b_op, acc;

   logic stall, accept, wr_acc, rd_acc;
   logic ctrl_wr, clear, start, push_a, push_b;
   logic mac_clr, mac_en, enter_done;

   // Operand pushes cannot land while the sequencer is reading the buffers.
   assign stall  = (state_q == ST_RUN) && !dp.dp_lw &&
                   ((dp.dp_addr == DPU_A) || (dp.dp_addr == DPU_B));
   assign accept = dp.dp_req && !ack_q && !stall;
   assign wr_acc = accept && !dp.dp_lw;
   assign rd_acc = accept && dp.dp_lw;

   assign ctrl_wr = wr_acc && (dp.dp_addr == DPU_CTRL);
   assign clear   = ctrl_wr && dp.dp_write_data[CTRL_CLEAR];
   assign start   = ctrl_wr && dp.dp_write_data[CTRL_START] && !clear &&
                    (state_q != ST_RUN);
   assign push_a  = wr_acc && (dp.dp_addr == DPU_A);
   assign push_b  = wr_acc && (dp.dp_addr == DPU_B);

   assign n_next = (wa_q < wb_q) ? wa_q : wb_q;

   always_comb begin
      state_d    = state_q;
      mac_clr    = 1'b0;
      mac_en     = 1'b0;
      enter_done = 1'b0;
      n_done     = n_q;
      if (clear) begin
         state_d = ST_IDLE;
         mac_clr = 1'b1;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  mac_clr = 1'b1;
                  if (n_next == '0) begin
                     state_d    = ST_DONE;
                     enter_done = 1'b1;
                     n_done     = '0;
                  end else begin
                     state_d = ST_RUN;
                  end
               end
            end
            ST_RUN: begin
               mac_en = 1'b1;
               if (idx_q + ONE == n_q) begin
                  state_d    = ST_DONE;
                  enter_done = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      a_op = '0;
      b_op = '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (idx_q == PW'(i)) begin
            a_op = buf_a[i];
            b_op = buf_b[i];
         end
      end
   end

   always_comb begin
      status                     = '0;
      status[STAT_BUSY]          = (state_q == ST_RUN);
      status[STAT_DONE]          = (state_q == ST_DONE);
      status[STAT_OVF]           = ovf_q;
      status[STAT_WA_LSB +: 4]   = 4'(wa_q);
      status[STAT_WB_LSB +: 4]   = 4'(wb_q);
   end

   always_comb begin
      rd_mux = '0;
      case (dp.dp_addr)
         DPU_CTRL: rd_mux = status;
         DPU_A:    rd_mux = acc;
         DPU_B:    rd_mux = 32'(n_last_q);
         default:  rd_mux = '0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= ST_IDLE;
         wa_q     <= '0;
         wb_q     <= '0;
         idx_q    <= '0;
         n_q      <= '0;
         n_last_q <= '0;
         ovf_q    <= 1'b0;
         ack_q    <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q <= state_d;
         ack_q   <= accept;
         rdata_q <= rd_acc ? rd_mux : '0;
         if (clear) begin
            wa_q     <= '0;
            wb_q     <= '0;
            idx_q    <= '0;
            n_last_q <= '0;
            ovf_q    <= 1'b0;
         end else begin
            if (start) begin
               idx_q <= '0;
               n_q   <= n_next;
            end else if (mac_en) begin
               idx_q <= idx_q + ONE;
            end
            // Completion consumes the operands; a stalled push then lands at slot 0.
            if (enter_done) begin
               wa_q     <= '0;
               wb_q     <= '0;
               n_last_q <= n_done;
            end
            if (push_a) begin
               if (wa_q == FULL) ovf_q <= 1'b1;
               else              wa_q  <= wa_q + ONE;
            end
            if (push_b) begin
               if (wb_q == FULL) ovf_q <= 1'b1;
               else              wb_q  <= wb_q + ONE;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (push_a && (wa_q != FULL) && (wa_q == PW'(i))) buf_a[i] <= dp.dp_write_data;
         if (push_b && (wb_q != FULL) && (wb_q == PW'(i))) buf_b[i] <= dp.dp_write_data;
      end
   end

   dpu_mac u_mac (
      .clk (clk),
      .rst (rst),
      .clr (mac_clr),
      .en  (mac_en),
      .a   (a_op),
      .b   (b_op),
      .acc (acc)
   );

   assign dp.dp_ack       = ack_q;
   assign dp.dp_read_data = rdata_q;

endmodule
